// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-enabled RAM with registered read data and WAIT_CYCLES wait states.
// Optional out-of-range address detection (data_sram_err) is enabled by defining DSRAM_ADDR_CHECK_EN.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
`ifdef DSRAM_ADDR_CHECK_EN
  ,
  output logic        data_sram_err
`endif
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] W         = WAIT_CYCLES[3:0];
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        stall_raw;
  logic        acc_fire;

  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [3:0]  acc_wen;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic        addr_bad;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // With zero wait states the access fires at the acceptance edge and the FSM never leaves IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    acc_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          if (ZERO_WAIT) begin
            acc_fire = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'd1;
            stall_raw = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt != W) begin
          cnt_nxt   = cnt + 4'd1;
          stall_raw = 1'b1;
        end else begin
          acc_fire  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign stallreq = stall_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wen   <= 4'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
    end else if (state == IDLE && data_sram_en) begin
      req_wen   <= data_sram_wen;
      req_addr  <= data_sram_addr;
      req_wdata <= data_sram_wdata;
    end
  end

  assign acc_wen   = ZERO_WAIT ? data_sram_wen   : req_wen;
  assign acc_addr  = ZERO_WAIT ? data_sram_addr  : req_addr;
  assign acc_wdata = ZERO_WAIT ? data_sram_wdata : req_wdata;
  assign acc_idx   = acc_addr[ADDR_WIDTH+1:2];

`ifdef DSRAM_ADDR_CHECK_EN
  assign addr_bad = |acc_addr[31:ADDR_WIDTH+2];
`else
  assign addr_bad = 1'b0;
`endif

  // Low address bits never select anything; upper bits alias unless checked.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_WIDTH+2]};

  // RAM contents are deliberately not reset; rst also blocks a write at an edge it overlaps.
  always_ff @(posedge clk) begin
    if (acc_fire && !rst && !addr_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wen[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= 32'd0;
    end else if (acc_fire && acc_wen == 4'd0) begin
      data_sram_rdata <= addr_bad ? 32'd0 : mem[acc_idx];
    end
  end

`ifdef DSRAM_ADDR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_err <= 1'b0;
    end else begin
      data_sram_err <= acc_fire & addr_bad;
    end
  end
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: one zero-wait instance and one two-wait-state instance
// checked against an array-based memory model.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en0, en2;
  logic [3:0]  wen0, wen2;
  logic [31:0] addr0, addr2, wdata0, wdata2;
  logic [31:0] rdata0, rdata2;
  logic        stall0, stall2;
`ifdef DSRAM_ADDR_CHECK_EN
  logic        err0, err2;
`endif

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0),
    .data_sram_rdata(rdata0), .stallreq(stall0)
`ifdef DSRAM_ADDR_CHECK_EN
    , .data_sram_err(err0)
`endif
  );

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .data_sram_en(en2), .data_sram_wen(wen2),
    .data_sram_addr(addr2), .data_sram_wdata(wdata2),
    .data_sram_rdata(rdata2), .stallreq(stall2)
`ifdef DSRAM_ADDR_CHECK_EN
    , .data_sram_err(err2)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m0 [1024];
  logic [31:0] m2 [1024];
  logic [31:0] r0, r2;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = w[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
`ifdef DSRAM_ADDR_CHECK_EN
    a[31:12] = 20'd0;
`endif
    return a;
  endfunction

  // Called at posedge+1; returns at the following posedge+1 with the request dropped.
  task automatic op0(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    en0 = 1'b1; wen0 = we; addr0 = a; wdata0 = wd;
    #1;
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL op0_stall got %b exp 0", stall0); end
    @(posedge clk);
    if (we == 4'd0) r0 = m0[a[11:2]];
    else m0[a[11:2]] = merge(m0[a[11:2]], wd, we);
    #1;
    en0 = 1'b0;
    checks++;
    if (rdata0 !== r0) begin errors++; $display("FAIL op0_rdata addr %h got %h exp %h", a, rdata0, r0); end
`ifdef DSRAM_ADDR_CHECK_EN
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL op0_err got %b exp 0", err0); end
`endif
  endtask

  // Holds the request until stallreq drops, then expects the access two edges after acceptance.
  task automatic op2(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    int nst;
    en2 = 1'b1; wen2 = we; addr2 = a; wdata2 = wd;
    #1;
    nst = 0;
    while (stall2 === 1'b1 && nst < 20) begin
      nst++;
      @(posedge clk);
      #2;
    end
    checks++;
    if (nst != 2) begin errors++; $display("FAIL op2_stall_cycles got %0d exp 2", nst); end
    @(posedge clk);
    if (we == 4'd0) r2 = m2[a[11:2]];
    else m2[a[11:2]] = merge(m2[a[11:2]], wd, we);
    #1;
    en2 = 1'b0;
    checks++;
    if (rdata2 !== r2) begin errors++; $display("FAIL op2_rdata addr %h got %h exp %h", a, rdata2, r2); end
    #1;
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL op2_reissue stall got %b exp 0", stall2); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h10; wdata0 = 32'h0;
    en2 = 1'b1; wen2 = 4'hF; addr2 = 32'h10; wdata2 = 32'h0;
    #3;
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL reset_stall2 got %b exp 0", stall2); end
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall0 got %b exp 0", stall0); end
    @(posedge clk);
    #1;
    en0 = 1'b0; en2 = 1'b0;
    checks++;
    if (rdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
    checks++;
    if (rdata2 !== 32'd0) begin errors++; $display("FAIL reset_rdata2 got %h exp 0", rdata2); end
    rst = 1'b0;
    r0 = 32'd0; r2 = 32'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 1024; i++) op0(4'hF, i << 2, $urandom);
    for (int i = 0; i < 1024; i++) op2(4'hF, i << 2, $urandom);
  endtask

  task automatic test_write_read();
    op0(4'hF, 32'h10, 32'hDEADBEEF);
    op0(4'h0, 32'h10, 32'h0);
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read got %h exp deadbeef", rdata0); end
  endtask

  task automatic test_partial();
    op0(4'hF, 32'h10, 32'h11223344);
    op0(4'b0010, 32'h10, 32'h0000AA00);
    op0(4'h0, 32'h10, 32'h0);
    checks++;
    if (rdata0 !== 32'h1122AA44) begin errors++; $display("FAIL partial got %h exp 1122aa44", rdata0); end
  endtask

  task automatic test_back_to_back();
    op0(4'h0, 32'h0, 32'h0);
    op0(4'h0, 32'h4, 32'h0);
    op0(4'h0, 32'h8, 32'h0);
  endtask

  task automatic test_wait();
    op2(4'h0, 32'h20, 32'h0);
    op2(4'b1001, 32'h20, $urandom);
    op2(4'h0, 32'h20, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    old = m2[4];
    en2 = 1'b1; wen2 = 4'hF; addr2 = 32'h10; wdata2 = ~old;
    #1;
    checks++;
    if (stall2 !== 1'b1) begin errors++; $display("FAIL rstmid_stall_c0 got %b exp 1", stall2); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    r0 = 32'd0; r2 = 32'd0;
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall2); end
    checks++;
    if (rdata2 !== 32'd0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", rdata2); end
    en2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    op2(4'h0, 32'h10, 32'h0);
    checks++;
    if (rdata2 !== old) begin errors++; $display("FAIL rstmid_old got %h exp %h", rdata2, old); end
    op2(4'hF, 32'h10, 32'hCAFEF00D);
    op2(4'h0, 32'h10, 32'h0);
  endtask

  task automatic test_random0();
    logic [3:0] we;
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(1, 15))) : 4'd0;
      op0(we, rand_addr(), $urandom);
    end
  endtask

  task automatic test_random2();
    logic [3:0] we;
    for (int i = 0; i < 100; i++) begin
      we = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(1, 15))) : 4'd0;
      op2(we, rand_addr(), $urandom);
    end
  endtask

`ifdef DSRAM_ADDR_CHECK_EN
  task automatic test_addr_check();
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h00001010; wdata0 = ~m0[4];
    @(posedge clk);
    #1;
    en0 = 1'b0;
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL addrchk_err_wr got %b exp 1", err0); end
    @(posedge clk);
    #1;
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL addrchk_err_clear got %b exp 0", err0); end
    op0(4'h0, 32'h10, 32'h0);
    en0 = 1'b1; wen0 = 4'h0; addr0 = 32'h00001010;
    @(posedge clk);
    #1;
    en0 = 1'b0;
    r0 = 32'd0;
    checks++;
    if (rdata0 !== 32'd0) begin errors++; $display("FAIL addrchk_rdata got %h exp 0", rdata0); end
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL addrchk_err_rd got %b exp 1", err0); end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    en0 = 1'b0; wen0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;
    en2 = 1'b0; wen2 = 4'd0; addr2 = 32'd0; wdata2 = 32'd0;
    rst = 1'b1;
    r0 = 32'd0; r2 = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_write_read();
    test_partial();
    test_back_to_back();
    test_wait();
    test_reset_mid();
`ifdef DSRAM_ADDR_CHECK_EN
    test_addr_check();
`endif
    test_random0();
    test_random2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
